// File: rtl/draw_arbiter_if.sv
// Pixel and collision signal bundle between the video pipeline and draw_arbiter.
// The master side drives pixel requests and frame timing. The slave side
// (the arbiter) returns the arbitrated colour and the collision reports.
interface draw_arbiter_if #(
   parameter int FRAME_CNT_W = 8
);
   logic                   startOfFrame;
   logic [7:0]             RGB_backGround;
   logic                   draw_top_boarder;
   logic                   draw_bottom_boarder;
   logic                   draw_left_boarder;
   logic                   draw_right_boarder;
   logic                   ballDrawReq;
   logic [7:0]             RGB_ball;
   logic                   flipperDrawReq;
   logic [7:0]             RGB_flipper;
   logic [7:0]             RGB_out;
   logic                   hit_top;
   logic                   hit_bottom;
   logic                   hit_left;
   logic                   hit_right;
   logic                   hit_flipper;
   logic                   collisionValid;
   logic [FRAME_CNT_W-1:0] frameCount;

   modport master (
      output startOfFrame, RGB_backGround,
      output draw_top_boarder, draw_bottom_boarder, draw_left_boarder, draw_right_boarder,
      output ballDrawReq, RGB_ball, flipperDrawReq, RGB_flipper,
      input  RGB_out, hit_top, hit_bottom, hit_left, hit_right, hit_flipper,
      input  collisionValid, frameCount
   );

   modport slave (
      input  startOfFrame, RGB_backGround,
      input  draw_top_boarder, draw_bottom_boarder, draw_left_boarder, draw_right_boarder,
      input  ballDrawReq, RGB_ball, flipperDrawReq, RGB_flipper,
      output RGB_out, hit_top, hit_bottom, hit_left, hit_right, hit_flipper,
      output collisionValid, frameCount
   );
endinterface

// File: rtl/draw_arbiter.sv
// Pixel draw arbiter with per-frame collision reporting.
// Fixed priority: ball, then flipper, then background. The output colour is
// registered, so it appears one cycle after the inputs are sampled.
// Collisions are collected into sticky pending bits during a frame. At each
// frame boundary they are published on hit_*, together with a one-cycle
// collisionValid pulse when at least one of the published bits is set.
module draw_arbiter #(
   parameter logic [7:0] TRANSPARENT = 8'hFF,
   parameter int         FRAME_CNT_W = 8
) (
   input logic          clk,
   input logic          reset,
   draw_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

   // Collision vector bit order: {top, bottom, left, right, flipper}
   state_t                 state_reg;
   logic [4:0]             pending_reg;
   logic [4:0]             hit_reg;
   logic                   valid_reg;
   logic [7:0]             rgb_reg;
   logic [FRAME_CNT_W-1:0] frame_cnt_reg;

   logic       ball_eff;
   logic       flip_eff;
   logic [4:0] coll_now;
   logic [7:0] rgb_next;

   // Effective requests, the winning colour and this cycle's collisions
   always_comb begin
      ball_eff = bus.ballDrawReq    && (bus.RGB_ball    != TRANSPARENT);
      flip_eff = bus.flipperDrawReq && (bus.RGB_flipper != TRANSPARENT);
      rgb_next = bus.RGB_backGround;
      if (ball_eff) begin
         rgb_next = bus.RGB_ball;
      end else if (flip_eff) begin
         rgb_next = bus.RGB_flipper;
      end
      coll_now = {ball_eff && bus.draw_top_boarder,
                  ball_eff && bus.draw_bottom_boarder,
                  ball_eff && bus.draw_left_boarder,
                  ball_eff && bus.draw_right_boarder,
                  ball_eff && flip_eff};
   end

   // Frame FSM: colour pipeline, collision accumulation and report publishing
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         pending_reg   <= '0;
         hit_reg       <= '0;
         valid_reg     <= 1'b0;
         rgb_reg       <= 8'h00;
         frame_cnt_reg <= '0;
      end else begin
         rgb_reg   <= rgb_next;
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // The first frame starts here, so there is no previous frame to report.
               // Collisions seen at the boundary already belong to the new frame.
               if (bus.startOfFrame) begin
                  state_reg   <= ACTIVE;
                  pending_reg <= coll_now;
               end
            end
            ACTIVE, REPORT: begin
               if (bus.startOfFrame) begin
                  // Publish the finished frame, then clear the pending bits.
                  // Boundary-cycle collisions are loaded after the clear.
                  state_reg     <= REPORT;
                  hit_reg       <= pending_reg;
                  valid_reg     <= |pending_reg;
                  frame_cnt_reg <= frame_cnt_reg + 1'b1;
                  pending_reg   <= coll_now;
               end else begin
                  state_reg   <= ACTIVE;
                  pending_reg <= pending_reg | coll_now;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.RGB_out        = rgb_reg;
   assign bus.hit_top        = hit_reg[4];
   assign bus.hit_bottom     = hit_reg[3];
   assign bus.hit_left       = hit_reg[2];
   assign bus.hit_right      = hit_reg[1];
   assign bus.hit_flipper    = hit_reg[0];
   assign bus.collisionValid = valid_reg;
   assign bus.frameCount     = frame_cnt_reg;
endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter. A frame-level reference model is
// compared against the DUT every cycle. The model ORs collisions into a set
// per frame and publishes that set at every startOfFrame after the first one.
module tb_draw_arbiter;
   localparam int         FCW   = 8;
   localparam logic [7:0] TRANS = 8'hFF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   draw_arbiter_if #(.FRAME_CNT_W(FCW)) bus ();

   draw_arbiter #(.TRANSPARENT(TRANS), .FRAME_CNT_W(FCW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit         started;
   bit [4:0]   frame_set;   // {top, bottom, left, right, flipper}
   logic [7:0] exp_rgb;
   logic [4:0] exp_hit;
   bit         exp_cv;
   int         exp_fc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit rst, input bit sof, input logic [7:0] bg,
                        input logic [3:0] brd, input bit breq, input logic [7:0] bc,
                        input bit freq, input logic [7:0] fc);
      reset                   = rst;
      bus.startOfFrame        = sof;
      bus.RGB_backGround      = bg;
      bus.draw_top_boarder    = brd[3];
      bus.draw_bottom_boarder = brd[2];
      bus.draw_left_boarder   = brd[1];
      bus.draw_right_boarder  = brd[0];
      bus.ballDrawReq         = breq;
      bus.RGB_ball            = bc;
      bus.flipperDrawReq      = freq;
      bus.RGB_flipper         = fc;
   endtask

   // Advance the model on the current inputs, clock the DUT and compare
   task automatic cycle();
      bit       b, f;
      bit [4:0] c;
      b = bus.ballDrawReq && (bus.RGB_ball != TRANS);
      f = bus.flipperDrawReq && (bus.RGB_flipper != TRANS);
      c = '0;
      if (b) c = {bus.draw_top_boarder, bus.draw_bottom_boarder,
                  bus.draw_left_boarder, bus.draw_right_boarder, f};
      if (reset) begin
         started = 0; frame_set = '0; exp_rgb = 8'h00;
         exp_hit = '0; exp_cv = 0; exp_fc = 0;
      end else begin
         exp_rgb = b ? bus.RGB_ball : (f ? bus.RGB_flipper : bus.RGB_backGround);
         exp_cv  = 0;
         if (bus.startOfFrame) begin
            if (started) begin
               exp_hit = frame_set;
               exp_cv  = (frame_set != 0);
               exp_fc  = (exp_fc + 1) % (1 << FCW);
               $display("report frame=%0d hits=%b valid=%0b", exp_fc, exp_hit, exp_cv);
            end
            started   = 1;
            frame_set = c;
         end else if (started) begin
            frame_set = frame_set | c;
         end
      end
      @(posedge clk);
      #1;
      check("RGB_out", {24'h0, bus.RGB_out}, {24'h0, exp_rgb});
      check("hit", {27'h0, bus.hit_top, bus.hit_bottom, bus.hit_left,
                    bus.hit_right, bus.hit_flipper}, {27'h0, exp_hit});
      check("collisionValid", {31'h0, bus.collisionValid}, {31'h0, exp_cv});
      check("frameCount", {24'h0, bus.frameCount}, exp_fc);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 8'h5B, 4'b0000, 0, 8'h00, 0, 8'h00);
         cycle();
      end
   endtask

   task automatic do_reset();
      drive(1, 0, 8'h5B, 4'b0000, 0, 8'h00, 0, 8'h00);
      cycle();
      drive(1, 1, 8'h5B, 4'b1111, 1, 8'hE0, 1, 8'h1C);   // reset beats startOfFrame
      cycle();
   endtask

   task automatic sof_cycle();
      drive(0, 1, 8'h5B, 4'b0000, 0, 8'h00, 0, 8'h00);
      cycle();
   endtask

   initial begin
      drive(1, 0, 8'h00, 4'b0000, 0, 8'h00, 0, 8'h00);
      do_reset();
      check("reset_rgb", {24'h0, bus.RGB_out}, 32'h0);

      // Priority: ball over flipper over background, then a transparent ball
      drive(0, 0, 8'h5B, 4'b0000, 1, 8'hE0, 1, 8'h1C); cycle();
      check("prio_ball", {24'h0, bus.RGB_out}, 32'hE0);
      drive(0, 0, 8'h5B, 4'b0000, 1, 8'hFF, 1, 8'h1C); cycle();
      check("prio_flipper", {24'h0, bus.RGB_out}, 32'h1C);
      drive(0, 0, 8'h5B, 4'b1111, 1, 8'hFF, 1, 8'hFF); cycle();
      check("prio_bg", {24'h0, bus.RGB_out}, 32'h5B);

      // Left-border hit in the middle of a frame
      sof_cycle(); idle_cycles(3);
      drive(0, 0, 8'h5B, 4'b0010, 1, 8'hE0, 0, 8'h00); cycle();
      idle_cycles(2);
      sof_cycle();
      check("left_hit", {27'h0, bus.hit_top, bus.hit_bottom, bus.hit_left,
                         bus.hit_right, bus.hit_flipper}, 32'b00100);
      check("left_valid", {31'h0, bus.collisionValid}, 32'h1);
      idle_cycles(1);
      check("left_valid_drop", {31'h0, bus.collisionValid}, 32'h0);

      // Empty frame, then a top-border collision exactly on the boundary
      idle_cycles(3); sof_cycle();
      check("empty_valid", {31'h0, bus.collisionValid}, 32'h0);
      idle_cycles(2);
      drive(0, 1, 8'h5B, 4'b1000, 1, 8'hE0, 0, 8'h00); cycle();
      check("boundary_top_now", {31'h0, bus.hit_top}, 32'h0);
      idle_cycles(2); sof_cycle();
      check("boundary_top_next", {31'h0, bus.hit_top}, 32'h1);

      // Back-to-back boundaries, with collisions in the report cycle
      drive(0, 1, 8'h00, 4'b1111, 1, 8'h11, 1, 8'h22); cycle();
      drive(0, 0, 8'h00, 4'b0001, 1, 8'h11, 0, 8'h22); cycle();
      idle_cycles(1); sof_cycle();

      // Reset mid-frame discards a pending right hit
      idle_cycles(1);
      drive(0, 0, 8'h5B, 4'b0001, 1, 8'hE0, 0, 8'h00); cycle();
      do_reset();
      sof_cycle(); idle_cycles(2); sof_cycle(); idle_cycles(2); sof_cycle();
      check("post_reset_right", {31'h0, bus.hit_right}, 32'h0);

      // Counter wrap: 256 boundaries after the first one
      do_reset();
      sof_cycle();
      for (int i = 0; i < 256; i++) begin
         idle_cycles(1);
         sof_cycle();
      end
      check("wrap_zero", {24'h0, bus.frameCount}, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         bit         rst, sof, breq, freq;
         logic [3:0] brd;
         logic [7:0] bc, fc, bg;
         rst  = ($urandom_range(0, 599) == 0);
         sof  = ($urandom_range(0, 11) == 0);
         breq = $urandom_range(0, 1);
         freq = $urandom_range(0, 1);
         for (int k = 0; k < 4; k++) brd[k] = ($urandom_range(0, 3) == 0);
         bc   = ($urandom_range(0, 3) == 0) ? TRANS : 8'($urandom);
         fc   = ($urandom_range(0, 3) == 0) ? TRANS : 8'($urandom);
         bg   = 8'($urandom);
         drive(rst, sof, bg, brd, breq, bc, freq, fc);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TRANSPARENT, default 8'hFF, requester colour treated as "not drawing".
REQ-002 Parameter FRAME_CNT_W, default 8, width of frame counter.
REQ-003 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 startOfFrame  in  1  one-cycle pulse marking first pixel of a frame.
REQ-006 RGB_backGround  in  8  background colour {R3,G3,B2}.
REQ-007 draw_top_boarder, draw_bottom_boarder, draw_left_boarder, draw_right_boarder  in  1 each  border-pixel flags, cycle-aligned with RGB_backGround.
REQ-008 ballDrawReq  in  1  ball requests current pixel; RGB_ball  in  8  ball colour.
REQ-009 flipperDrawReq  in  1  flipper requests current pixel; RGB_flipper  in  8  flipper colour.
REQ-010 RGB_out  out  8  arbitrated pixel colour, registered.
REQ-011 hit_top, hit_bottom, hit_left, hit_right, hit_flipper  out  1 each  collisions of previous frame, registered.
REQ-012 collisionValid  out  1  one-cycle pulse: new collision report published.
REQ-013 frameCount  out  FRAME_CNT_W  completed-frame counter.

Function
REQ-014 All inputs SHALL be sampled in the same cycle; no internal realignment.
REQ-015 Effective ball request = ballDrawReq AND RGB_ball != TRANSPARENT; same rule for flipper.
REQ-016 Fixed priority: ball > flipper > background; RGB_out SHALL equal winner colour one cycle after sampling (latency 1).
REQ-017 Background always draws; border pixels pass through with background colour unchanged.
REQ-018 State machine states: IDLE, ACTIVE, REPORT.
REQ-019 IDLE: RGB_out arbitrated per REQ-016; collisions ignored; startOfFrame -> ACTIVE, pending bits cleared.
REQ-020 ACTIVE: each cycle with effective ball request AND draw_X_boarder SHALL set pending bit X; effective ball AND effective flipper SHALL set pending flipper bit.
REQ-021 Pending bits SHALL be sticky until frame boundary.
REQ-022 ACTIVE + startOfFrame -> REPORT; pending bits copied to hit_* outputs same edge; frameCount increments.
REQ-023 Collision present in the same cycle as startOfFrame SHALL belong to the new frame (set pending after clear), not the reported frame.
REQ-024 REPORT lasts exactly one cycle; collisionValid = 1 during REPORT only if any reported hit_* bit = 1, else 0; then -> ACTIVE.
REQ-025 Collisions in REPORT cycle SHALL accumulate into the new frame's pending bits.
REQ-026 startOfFrame during REPORT SHALL be treated as another boundary: report (possibly empty) pending, stay REPORT one more cycle.
REQ-027 hit_* outputs SHALL hold until the next report.
REQ-028 frameCount SHALL wrap from 2^FRAME_CNT_W-1 to 0 without flag.
REQ-029 Multiple border flags set simultaneously with ball SHALL set all corresponding pending bits.

Reset
REQ-030 On reset high at a clock edge: RGB_out = 8'h00, all hit_* = 0, collisionValid = 0, frameCount = 0, pending = 0, state = IDLE.
REQ-031 Reset asserted mid-frame or during REPORT SHALL discard pending collisions and suppress any collisionValid pulse in that cycle.
REQ-032 Reset SHALL dominate startOfFrame in the same cycle.

Verification
REQ-033 Priority: ballDrawReq=1, RGB_ball=8'hE0, flipperDrawReq=1, RGB_flipper=8'h1C, RGB_backGround=8'h5B -> RGB_out=8'hE0 next cycle; RGB_ball=8'hFF -> 8'h1C.
REQ-034 Border hit: ball on draw_left_boarder for one cycle mid-frame, then startOfFrame -> hit_left=1, others 0, collisionValid=1 for one cycle, frameCount=1.
REQ-035 Empty frame: no collisions, startOfFrame -> hit_*=0, collisionValid stays 0, frameCount increments.
REQ-036 Boundary collision: ball+draw_top_boarder in the startOfFrame cycle -> hit_top=0 in this report, hit_top=1 at next report.
REQ-037 Reset mid-frame: pending hit_right set, reset pulse, then two frames -> outputs all 0 after reset, no collisionValid until a new collision occurs.
REQ-038 Wrap: 256 startOfFrame pulses after the first -> frameCount returns to 0.
